wb_mem_2_ppfifo: RTL
====================

Name: wb_mem_2_ppfifo

Overview:
Wishbone master that reads two software-armed memory banks and streams the words into the write side of a ping-pong FIFO. It is the read-direction counterpart of the FIFO-to-memory writer.
Software programs each bank with a base and size, then pulses new_data. The block serves the banks alternately: bank 0, then 1, then 0, and so on.
It sits between the memory arbiter (master port) and any downstream ppfifo consumer.

Parameters:
DEFAULT_MEM_0_BASE, 32'h00000000, reset base of bank 0, driven on o_default_mem_0_base
DEFAULT_MEM_1_BASE, 32'h00100000, reset base of bank 1, driven on o_default_mem_1_base
FIFO_SIZE_WIDTH, 24, width of the ppfifo size input

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  run enable
i_memory_0_base / i_memory_1_base  in  32  bank word base address
i_memory_0_size / i_memory_1_size  in  32  bank length in words
i_memory_0_new_data / i_memory_1_new_data  in  1  one-cycle arm pulse
o_memory_0_count / o_memory_1_count  out  32  words read so far from the bank
o_memory_0_empty / o_memory_1_empty  out  1  bank drained (or never armed)
o_default_mem_0_base / o_default_mem_1_base  out  32  parameter values
o_read_finished  out  1  one-cycle pulse when a bank completes
o_mem_we, o_mem_stb, o_mem_cyc  out  1  wishbone master controls
o_mem_sel  out  4  byte select
o_mem_adr, o_mem_dat  out  32  address and write data
i_mem_dat  in  32  read data
i_mem_ack, i_mem_int  in  1  acknowledge; interrupt (unused)
i_ppfifo_rdy  in  2  write-side ready per half
o_ppfifo_act  out  2  write-side activate
i_ppfifo_size  in  FIFO_SIZE_WIDTH  capacity of the activated half
o_ppfifo_stb  out  1  write strobe
o_ppfifo_data  out  32  write data

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - all mem and ppfifo outputs are 0 and o_read_finished = 0
  - counts are 0 and both empty flags are 1
  - the next bank to serve is bank 0
- Fixed outputs: o_mem_we = 0, o_mem_dat = 0, o_mem_sel = 4'hF. o_mem_cyc equals o_mem_stb.
- Arming:
  - new_data with size > 0 on a bank that is empty: count <= 0, empty <= 0.
  - new_data with size 0, or on a bank that is not empty: ignored.
  - Base and size are sampled at arm time.
- States:
  - IDLE: if i_enable and the current bank is not empty and i_ppfifo_rdy != 0, set o_ppfifo_act to the lowest ready bit, clear the FIFO word count, and go to MEM_REQ. Otherwise stay.
  - MEM_REQ: drive stb/cyc = 1 with adr = base + bank count, then go to MEM_WAIT.
  - MEM_WAIT: hold stb/cyc until i_mem_ack. On ack, capture i_mem_dat into o_ppfifo_data, drop stb/cyc in the same registered edge, and go to FIFO_WR.
  - FIFO_WR: pulse o_ppfifo_stb for 1 cycle and increment both the bank count and the FIFO count.
    - Bank count reaches size: set empty, pulse o_read_finished, toggle the current bank, go to RELEASE.
    - Else FIFO count reaches i_ppfifo_size, or i_enable = 0: go to RELEASE.
    - Else: go to MEM_REQ.
  - RELEASE: o_ppfifo_act <= 0, then go to IDLE.
- Throughput: 3 cycles per word plus memory wait states. A partially filled FIFO half is released at end of bank.
- Disable mid-transfer: the outstanding wishbone read always completes and its word is written. The FIFO half is then released; bank progress is kept and resumes on re-enable.
- No FIFO half ready: wait in IDLE with no bus activity.
- Both banks armed: strict alternation. The non-current bank is never served first, even if the current bank is empty.
- Address width: bank count is 32-bit and address wraps modulo 2^32.
- Asynchronous reset mid-cycle drops stb/cyc immediately. A late i_mem_ack after reset is ignored.

Decomposition:
- Package wb_mem_2_ppfifo_pkg holds:
  - the state enum (IDLE, MEM_REQ, MEM_WAIT, FIFO_WR, RELEASE)
  - SEL_ALL = 4'hF
  - the default base constants
- Sub-module mem_bank_ctrl is instantiated twice. Each instance holds base, size, count and empty, and takes arm/advance inputs.
- The FSM stays in the top module.

Test Plan:
- Arm bank 0 (base 0x100, size 4), FIFO size 4, ack after 1 cycle -> reads at 0x100..0x103 and 4 strobes with the memory data. The half is released, o_memory_0_empty = 1, and o_read_finished pulses once.
- Bank 0 size 10, FIFO size 4 -> activations of 4, 4 and 2 words; final o_memory_0_count = 10.
- Arm both banks (size 3 each, bases 0x0 and 0x1000) -> all bank 0 reads precede bank 1 reads; two finished pulses.
- Drop i_enable after the 2nd ack of a size-8 bank -> the 2nd word is written, act drops, no further stb. On re-enable, reads resume at base+2.
- Arm with size 0, and re-arm an active bank -> both ignored; empty flags and counts unchanged.
- Assert rst_n = 0 while o_mem_stb = 1 with ack withheld -> stb/cyc/act are 0 immediately; empty = 1 and count = 0 after reset.

Source files
------------

// File: rtl/wb_mem_2_ppfifo_pkg.sv
// Shared types and constants for the memory-to-ppfifo reader.
// The FSM states, the byte-select value and the default bank bases live here.
package wb_mem_2_ppfifo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        FIFO_WR,
        RELEASE
    } state_t;

    localparam logic [3:0]  SEL_ALL        = 4'hF;
    localparam logic [31:0] DEF_MEM_0_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_MEM_1_BASE = 32'h0010_0000;

endpackage

// File: rtl/mem_bank_ctrl.sv
// One software-armed memory bank: latches base/size on arm and tracks
// how many words have been read out until the bank is drained.
module mem_bank_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_arm,
    input  logic [31:0] i_base,
    input  logic [31:0] i_size,
    input  logic        i_advance,
    output logic [31:0] o_adr,
    output logic [31:0] o_count,
    output logic        o_empty,
    output logic        o_last
);

    logic [31:0] base_q, base_d;
    logic [31:0] size_q, size_d;
    logic [31:0] count_q, count_d;
    logic        empty_q, empty_d;
    logic [31:0] count_inc;

    assign count_inc = count_q + 32'd1;

    // Arming is only honoured on a drained bank, so an active bank
    // can never have its base or size changed under it.
    always_comb begin
        base_d  = base_q;
        size_d  = size_q;
        count_d = count_q;
        empty_d = empty_q;
        if (i_arm && empty_q && (i_size != 32'd0)) begin
            base_d  = i_base;
            size_d  = i_size;
            count_d = 32'd0;
            empty_d = 1'b0;
        end else if (i_advance && !empty_q) begin
            count_d = count_inc;
            if (count_inc == size_q) begin
                empty_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= 32'd0;
            size_q  <= 32'd0;
            count_q <= 32'd0;
            empty_q <= 1'b1;
        end else begin
            base_q  <= base_d;
            size_q  <= size_d;
            count_q <= count_d;
            empty_q <= empty_d;
        end
    end

    assign o_adr   = base_q + count_q;
    assign o_count = count_q;
    assign o_empty = empty_q;
    assign o_last  = (count_inc == size_q);

endmodule

// File: rtl/wb_mem_2_ppfifo.sv
// Wishbone master that drains two alternating memory banks into the
// write side of a ping-pong FIFO, one word per three-cycle transaction.
module wb_mem_2_ppfifo
    import wb_mem_2_ppfifo_pkg::*;
#(
    parameter logic [31:0] DEFAULT_MEM_0_BASE = DEF_MEM_0_BASE,
    parameter logic [31:0] DEFAULT_MEM_1_BASE = DEF_MEM_1_BASE,
    parameter int          FIFO_SIZE_WIDTH    = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_enable,
    input  logic [31:0]                i_memory_0_base,
    input  logic [31:0]                i_memory_0_size,
    input  logic                       i_memory_0_new_data,
    input  logic [31:0]                i_memory_1_base,
    input  logic [31:0]                i_memory_1_size,
    input  logic                       i_memory_1_new_data,
    output logic [31:0]                o_memory_0_count,
    output logic [31:0]                o_memory_1_count,
    output logic                       o_memory_0_empty,
    output logic                       o_memory_1_empty,
    output logic [31:0]                o_default_mem_0_base,
    output logic [31:0]                o_default_mem_1_base,
    output logic                       o_read_finished,
    output logic                       o_mem_we,
    output logic                       o_mem_stb,
    output logic                       o_mem_cyc,
    output logic [3:0]                 o_mem_sel,
    output logic [31:0]                o_mem_adr,
    output logic [31:0]                o_mem_dat,
    input  logic [31:0]                i_mem_dat,
    input  logic                       i_mem_ack,
    input  logic                       i_mem_int,
    input  logic [1:0]                 i_ppfifo_rdy,
    output logic [1:0]                 o_ppfifo_act,
    input  logic [FIFO_SIZE_WIDTH-1:0] i_ppfifo_size,
    output logic                       o_ppfifo_stb,
    output logic [31:0]                o_ppfifo_data
);

    state_t                     state_q, state_d;
    logic                       bank_q, bank_d;
    logic [1:0]                 act_q, act_d;
    logic                       stb_q, stb_d;
    logic [31:0]                adr_q, adr_d;
    logic [31:0]                dat_q, dat_d;
    logic                       fstb_q, fstb_d;
    logic [FIFO_SIZE_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                       fin_q, fin_d;

    logic [FIFO_SIZE_WIDTH-1:0] fcnt_inc;
    logic [1:0]                 adv;
    logic [31:0]                adr0, adr1;
    logic                       last0, last1;
    logic                       cur_empty, cur_last;
    logic [31:0]                cur_adr;
    logic                       unused_int;

    assign unused_int = i_mem_int;

    mem_bank_ctrl u_bank0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_arm     (i_memory_0_new_data),
        .i_base    (i_memory_0_base),
        .i_size    (i_memory_0_size),
        .i_advance (adv[0]),
        .o_adr     (adr0),
        .o_count   (o_memory_0_count),
        .o_empty   (o_memory_0_empty),
        .o_last    (last0)
    );

    mem_bank_ctrl u_bank1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_arm     (i_memory_1_new_data),
        .i_base    (i_memory_1_base),
        .i_size    (i_memory_1_size),
        .i_advance (adv[1]),
        .o_adr     (adr1),
        .o_count   (o_memory_1_count),
        .o_empty   (o_memory_1_empty),
        .o_last    (last1)
    );

    assign cur_empty = bank_q ? o_memory_1_empty : o_memory_0_empty;
    assign cur_last  = bank_q ? last1 : last0;
    assign cur_adr   = bank_q ? adr1 : adr0;
    assign fcnt_inc  = fcnt_q + FIFO_SIZE_WIDTH'(1);
    assign adv       = (state_q == FIFO_WR) ? (bank_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        act_d   = act_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        fstb_d  = 1'b0;
        fcnt_d  = fcnt_q;
        fin_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_enable && !cur_empty && (i_ppfifo_rdy != 2'b00)) begin
                    act_d   = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
                    fcnt_d  = '0;
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                stb_d   = 1'b1;
                adr_d   = cur_adr;
                state_d = MEM_WAIT;
            end
            // The read always completes, even if enable drops meanwhile.
            MEM_WAIT: begin
                if (i_mem_ack) begin
                    dat_d   = i_mem_dat;
                    stb_d   = 1'b0;
                    fstb_d  = 1'b1;
                    state_d = FIFO_WR;
                end
            end
            FIFO_WR: begin
                fcnt_d = fcnt_inc;
                if (cur_last) begin
                    fin_d   = 1'b1;
                    bank_d  = ~bank_q;
                    state_d = RELEASE;
                end else if ((fcnt_inc == i_ppfifo_size) || !i_enable) begin
                    state_d = RELEASE;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            RELEASE: begin
                act_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_q  <= 1'b0;
            act_q   <= 2'b00;
            stb_q   <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            fstb_q  <= 1'b0;
            fcnt_q  <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            act_q   <= act_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            fstb_q  <= fstb_d;
            fcnt_q  <= fcnt_d;
            fin_q   <= fin_d;
        end
    end

    assign o_default_mem_0_base = DEFAULT_MEM_0_BASE;
    assign o_default_mem_1_base = DEFAULT_MEM_1_BASE;
    assign o_read_finished      = fin_q;
    assign o_mem_we             = 1'b0;
    assign o_mem_stb            = stb_q;
    assign o_mem_cyc            = stb_q;
    assign o_mem_sel            = SEL_ALL;
    assign o_mem_adr            = adr_q;
    assign o_mem_dat            = 32'd0;
    assign o_ppfifo_act         = act_q;
    assign o_ppfifo_stb         = fstb_q;
    assign o_ppfifo_data        = dat_q;

endmodule
